fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch and program-counter stage that sits directly upstream of the control unit. It fetches one 32-bit instruction per 8-phase instruction period over a req/ack instruction-memory handshake. It holds the fetched word in a decode register, whose opcode field the control unit samples, and an execute register whose fields feed the datapath. It computes the next PC from the control unit's PC-mux select and the datapath's `equ`/`les` flags.

## Interface
- `ADDR_W`, 16: PC and instruction-memory address width
- `RESET_PC`, 0: PC value loaded on reset
- `clk`  in  1: clock, rising edge
- `rst_n`  in  1: reset, asynchronous, active-low
- `pc_sel`  in  3: PC-mux select from control unit (sel[2:0]); valid for the instruction in `ex_ir`
- `equ`, `les`  in  1 each: datapath compare flags for `ex_ir`; valid by phase 4
- `rs_value`  in  32: register-file source value, used by jump-register
- `imem_req`  out  1: fetch request
- `imem_addr`  out  ADDR_W: fetch address (= `pc`)
- `imem_ack`  in  1: one-cycle acknowledge; `imem_rdata` valid in the same cycle
- `imem_rdata`  in  32: fetched instruction
- `opcode`  out  6: `ir[31:26]`, sampled by control unit
- `ex_ir`  out  32: instruction currently executing
- `pc`  out  ADDR_W: program counter
- `phase`  out  3: instruction-period phase 0..7
- `hold`  out  1: control unit must freeze its phase counter while high
- `halted`  out  1: sticky, set by halt select
- `sel_err`  out  1: sticky, set by an illegal `pc_sel`

## Operation
- Phase counter 0..7 advances by one per cycle unless `hold` is high; it wraps 7->0.
- EXEC (phases 0-3): no action; `ex_ir` stable.
- UPDATE (phase 4): `pc` <= next_pc:
  - sel 0: `rs_value[ADDR_W-1:0]`
  - sel 1: branch. Taken if (`ex_ir` opcode 30 and `equ`) or (opcode 31 and `les`). Taken -> `pc` + sign-extended `ex_ir[15:0]`; not taken -> `pc`+1.
  - sel 2: `ex_ir[ADDR_W-1:0]` (absolute jump)
  - sel 3: `pc`+1
  - sel 4: `pc` unchanged; `halted` <= 1
  - sel 5-7: treated as sel 3; `sel_err` <= 1
- All PC arithmetic is modulo 2^ADDR_W: 2^ADDR_W-1 + 1 -> 0; negative offset below 0 wraps.
- FETCH (phase 5): `imem_req`=1, `imem_addr`=`pc`. `hold`=1 until `imem_ack`. On the ack edge, `ir` <= `imem_rdata`, `imem_req` drops and the phase advances to 6. `imem_ack` outside FETCH is ignored.
- DECODE (phases 6-7): `opcode` stable. On the phase-7 edge (with `hold` low), the control unit samples `opcode` and `ex_ir` <= `ir`.
- Halted: after the phase-4 update with sel 4, the phase freezes at 4, `hold`=1, no further fetches. Only reset exits this state.

## Timing
- Reset (asynchronous, immediate): `pc`=RESET_PC, `ir`=0, `ex_ir`=0, `phase`=5, `imem_req`=0, `hold`=0, `halted`=0, `sel_err`=0.
- After reset release, `imem_req` rises in the first cycle (phase 5); the first instruction needs no prior PC update.
- Zero-wait memory (ack in the req cycle): period = 8 cycles. Each wait cycle adds one cycle; `hold` is high for exactly those cycles.
- Reset during FETCH drops `imem_req` asynchronously. The memory shares `rst_n` and discards the pending request.
- `pc_sel`, `equ`, `les` and `rs_value` are sampled only at the phase-4 edge.

## Structure
- Shared `cpu_pkg`: opcode constants (BEQ=30, BLT=31, JMP=29, JR=28, HALT=0), PC-select encodings 0-4, phase constants (UPDATE=4, FETCH=5, LAST=7), instruction field positions.
- Sub-module `next_pc_calc`: combinational next-PC and `sel_err`/halt decode from `pc`, `pc_sel`, flags, `ex_ir` and `rs_value`. The FSM, phase counter and registers stay in `fetch_unit`.

## Test plan
- Reset release, zero-wait memory, words at 0..3 with `pc_sel`=3 -> `imem_addr` 0,1,2,3 every 8 cycles; `opcode` valid at phases 6-7.
- Ack delayed 3 cycles -> `hold` high exactly 3 cycles at phase 5; period 11; `ir` captures the acked word.
- `ex_ir` opcode 30, offset 0xFFFE, `pc`=0x0010, `equ`=1, sel 1 -> next fetch at 0x000E. Same with `equ`=0 -> 0x0011.
- `pc`=0xFFFF, sel 3 -> fetch at 0x0000. sel 0 with `rs_value`=0x1234ABCD -> fetch at 0xABCD.
- sel 4 -> `halted`=1, phase frozen at 4, no `imem_req` for 50 cycles. sel 6 -> `sel_err`=1, PC+1.
- `rst_n` low mid-FETCH -> `imem_req` low immediately; after release, fetch at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants: opcodes, PC-mux selects, phases.
// Also instruction field positions and the immediate sign-extend helper.
package cpu_pkg;

  localparam logic [5:0] OP_HALT = 6'd0;
  localparam logic [5:0] OP_JR   = 6'd28;
  localparam logic [5:0] OP_JMP  = 6'd29;
  localparam logic [5:0] OP_BEQ  = 6'd30;
  localparam logic [5:0] OP_BLT  = 6'd31;

  typedef enum logic [2:0] {
    SEL_JR   = 3'd0,
    SEL_BR   = 3'd1,
    SEL_JMP  = 3'd2,
    SEL_INC  = 3'd3,
    SEL_HALT = 3'd4
  } pc_sel_e;

  localparam logic [2:0] PH_UPDATE = 3'd4;
  localparam logic [2:0] PH_FETCH  = 3'd5;
  localparam logic [2:0] PH_LAST   = 3'd7;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int IMM_MSB = 15;

  typedef enum logic {
    MODE_RUN  = 1'b0,
    MODE_HALT = 1'b1
  } mode_e;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection for the fetch stage.
// Also flags halt and illegal PC-mux selects.
module next_pc_calc
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [2:0]        pc_sel,
  input  logic              equ,
  input  logic              les,
  input  logic [31:0]       ex_ir,
  input  logic [31:0]       rs_value,
  output logic [ADDR_W-1:0] next_pc,
  output logic              halt,
  output logic              sel_err
);

  logic [5:0]        op;
  logic [31:0]       off;
  logic              taken;
  logic [ADDR_W-1:0] inc;
  logic              unused;

  assign op  = ex_ir[OP_MSB:OP_LSB];
  assign off = sext16(ex_ir[IMM_MSB:0]);
  assign inc = pc + ADDR_W'(1);
  assign unused = ^{rs_value, ex_ir, off};

  // Branch condition from the executing opcode and compare flags
  always_comb begin
    taken = ((op == OP_BEQ) && equ) ||
            ((op == OP_BLT) && les);
  end

  // PC-mux: wraps naturally at ADDR_W bits
  always_comb begin
    next_pc = inc;
    halt    = 1'b0;
    sel_err = 1'b0;
    unique case (1'b1)
      pc_sel == SEL_JR:
        next_pc = rs_value[ADDR_W-1:0];
      pc_sel == SEL_BR:
        next_pc = taken ?
          pc + off[ADDR_W-1:0] : inc;
      pc_sel == SEL_JMP:
        next_pc = ex_ir[ADDR_W-1:0];
      pc_sel == SEL_INC:
        next_pc = inc;
      pc_sel == SEL_HALT: begin
        next_pc = pc;
        halt    = 1'b1;
      end
      default:
        sel_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch / PC stage: 8-phase period, req/ack fetch,
// decode and execute instruction registers, next-PC update.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int              ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        pc_sel,
  input  logic              equ,
  input  logic              les,
  input  logic [31:0]       rs_value,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [5:0]        opcode,
  output logic [31:0]       ex_ir,
  output logic [ADDR_W-1:0] pc,
  output logic [2:0]        phase,
  output logic              hold,
  output logic              halted,
  output logic              sel_err
);

  mode_e             mode_q, mode_d;
  logic [2:0]        phase_q, phase_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [31:0]       ex_q, ex_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] npc;
  logic              npc_halt;
  logic              npc_err;
  logic              in_fetch;

  next_pc_calc #(
    .ADDR_W (ADDR_W)
  ) u_npc (
    .pc       (pc_q),
    .pc_sel   (pc_sel),
    .equ      (equ),
    .les      (les),
    .ex_ir    (ex_q),
    .rs_value (rs_value),
    .next_pc  (npc),
    .halt     (npc_halt),
    .sel_err  (npc_err)
  );

  // rst_n gating makes req/hold drop the instant reset asserts
  assign in_fetch  = (mode_q == MODE_RUN) &&
                     (phase_q == PH_FETCH);
  assign imem_req  = rst_n && in_fetch;
  assign hold      = rst_n &&
                     ((mode_q == MODE_HALT) ||
                      (in_fetch && !imem_ack));
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign phase     = phase_q;
  assign opcode    = ir_q[OP_MSB:OP_LSB];
  assign ex_ir     = ex_q;
  assign halted    = (mode_q == MODE_HALT);
  assign sel_err   = err_q;

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MODE_RUN;
      phase_q <= PH_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      ex_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      phase_q <= phase_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ex_q    <= ex_d;
      err_q   <= err_d;
    end
  end

  // Phase sequencing: update, fetch wait, decode hand-off
  always_comb begin
    mode_d  = mode_q;
    phase_d = phase_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ex_d    = ex_q;
    err_d   = err_q;
    if (mode_q == MODE_RUN) begin
      unique case (1'b1)
        phase_q == PH_UPDATE: begin
          pc_d  = npc;
          err_d = err_q || npc_err;
          if (npc_halt) mode_d  = MODE_HALT;
          else          phase_d = PH_FETCH;
        end
        phase_q == PH_FETCH: begin
          if (imem_ack) begin
            ir_d    = imem_rdata;
            phase_d = phase_q + 3'd1;
          end
        end
        phase_q == PH_LAST: begin
          ex_d    = ir_q;
          phase_d = 3'd0;
        end
        default:
          phase_d = phase_q + 3'd1;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed periods plus
// randomized periods against a per-instruction PC model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  pc_sel;
  logic        equ, les;
  logic [31:0] rs_value;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [5:0]  opcode;
  logic [31:0] ex_ir;
  logic [15:0] pc;
  logic [2:0]  phase;
  logic        hold, halted, sel_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int mpc = 0;
  bit merr = 0;
  bit mhalt = 0;
  bit have_prev = 0;
  int prev_cyc = 0;
  int prev_w = 0;

  fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_sel     (pc_sel),
    .equ        (equ),
    .les        (les),
    .rs_value   (rs_value),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .opcode     (opcode),
    .ex_ir      (ex_ir),
    .pc         (pc),
    .phase      (phase),
    .hold       (hold),
    .halted     (halted),
    .sel_err    (sel_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One instruction period: fetch word after w wait cycles,
  // then present sel/flags for its phase-4 update.
  task automatic do_period(input logic [31:0] word,
                           input int w,
                           input logic [2:0] sel,
                           input logic e,
                           input logic l,
                           input logic [31:0] rs);
    int n;
    int off;
    bit tk;
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", imem_req, 1);
    if (imem_req !== 1'b1) return;
    chk("fetch_addr", imem_addr, mpc);
    chk("fetch_phase", phase, 5);
    if (have_prev) chk("period", cyc - prev_cyc, 8 + prev_w);
    prev_cyc = cyc;
    prev_w = w;
    have_prev = 1;
    for (int i = 0; i < w; i++) begin
      chk("hold_wait", hold, 1);
      @(negedge clk);
      chk("phase_held", phase, 5);
    end
    imem_ack = 1'b1;
    imem_rdata = word;
    #1 chk("hold_ack", hold, 0);
    @(negedge clk);
    imem_ack = 1'b0;
    chk("phase6", phase, 6);
    chk("req_drop", imem_req, 0);
    chk("opcode6", opcode, word[31:26]);
    pc_sel = sel;
    equ = e;
    les = l;
    rs_value = rs;
    @(negedge clk);
    chk("opcode7", opcode, word[31:26]);
    @(negedge clk);
    chk("ex_ir", ex_ir, word);
    imem_ack = 1'b1;
    imem_rdata = ~word;
    @(negedge clk);
    imem_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("phase4", phase, 4);
    chk("opcode_kept", opcode, word[31:26]);
    @(negedge clk);
    off = int'($signed(word[15:0]));
    tk = (word[31:26] == 6'd30 && e) || (word[31:26] == 6'd31 && l);
    case (sel)
      3'd0: mpc = rs & 32'hFFFF;
      3'd1: mpc = tk ? ((mpc + off) & 32'hFFFF) : ((mpc + 1) & 32'hFFFF);
      3'd2: mpc = word & 32'hFFFF;
      3'd4: mhalt = 1;
      default: mpc = (mpc + 1) & 32'hFFFF;
    endcase
    if (sel > 3'd4) merr = 1;
    chk("pc_upd", pc, mpc);
    chk("sel_err", sel_err, merr);
    chk("halted", halted, mhalt);
    chk("phase_upd", phase, mhalt ? 4 : 5);
  endtask

  initial begin
    logic [2:0]  sel_tab [7];
    logic [31:0] word;
    int r;
    sel_tab = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
    rst_n = 1'b0;
    pc_sel = 3'd3;
    equ = 0;
    les = 0;
    rs_value = 0;
    imem_ack = 0;
    imem_rdata = 0;
    #12;
    chk("rst_pc", pc, 0);
    chk("rst_ex_ir", ex_ir, 0);
    chk("rst_opcode", opcode, 0);
    chk("rst_phase", phase, 5);
    chk("rst_req", imem_req, 0);
    chk("rst_hold", hold, 0);
    chk("rst_halted", halted, 0);
    chk("rst_sel_err", sel_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("req_first", imem_req, 1);

    for (int a = 0; a < 4; a++)
      do_period({6'd3, 26'(a * 77 + 5)}, 0, 3'd3, 0, 0, 0);
    do_period(32'h0C00_1234, 3, 3'd3, 0, 0, 0);
    do_period({6'd29, 10'd0, 16'h0010}, 0, 3'd2, 0, 0, 0);
    do_period({6'd30, 10'd0, 16'hFFFE}, 1, 3'd1, 1, 0, 0);
    do_period({6'd29, 10'd0, 16'h0010}, 0, 3'd2, 0, 0, 0);
    do_period({6'd30, 10'd0, 16'hFFFE}, 0, 3'd1, 0, 1, 0);
    do_period({6'd31, 10'd0, 16'h0005}, 2, 3'd1, 0, 1, 0);
    do_period({6'd29, 10'd0, 16'hFFFF}, 0, 3'd2, 0, 0, 0);
    do_period(32'h0400_0000, 0, 3'd3, 0, 0, 0);
    do_period({6'd28, 26'd0}, 0, 3'd0, 0, 0, 32'h1234_ABCD);
    do_period(32'h0800_0000, 0, 3'd6, 0, 0, 0);

    for (int k = 0; k < 24; k++) begin
      word = $urandom;
      r = $urandom_range(0, 3);
      if (r == 0) word[31:26] = 6'd30;
      if (r == 1) word[31:26] = 6'd31;
      do_period(word, $urandom_range(0, 3),
                sel_tab[$urandom_range(0, 6)],
                1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom);
    end

    do_period({6'd0, 26'd0}, 1, 3'd4, 0, 0, 0);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      chk("halt_req", imem_req, 0);
      chk("halt_phase", phase, 4);
      chk("halt_hold", hold, 1);
    end
    chk("halt_pc", pc, mpc);

    rst_n = 1'b0;
    #3;
    mpc = 0;
    merr = 0;
    mhalt = 0;
    have_prev = 0;
    chk("rst2_halted", halted, 0);
    chk("rst2_sel_err", sel_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst2_req", imem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midfetch_req", imem_req, 0);
    chk("midfetch_hold", hold, 0);
    chk("midfetch_phase", phase, 5);
    @(negedge clk);
    rst_n = 1'b1;
    do_period(32'h0C00_0042, 0, 3'd3, 0, 0, 0);
    do_period(32'h0C00_0043, 2, 3'd3, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
